// File: rtl/frame_masker_credit_ctrl_pkg.sv
// frame_masker_credit_ctrl_pkg: shared types and helpers for the credit-based
// frame release scheduler (control FSM state, popcount, credit item summing).
// Helpers take vectors zero-extended to MAX_VEC_W plus run-time widths so one
// definition serves every parameterisation of the block.
package frame_masker_credit_ctrl_pkg;

  localparam int unsigned MAX_VEC_W = 128;
  localparam int unsigned SUM_W     = 64;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } ctrl_state_e;

  // Number of set bits in the low 'width' bits of vec.
  function automatic int unsigned popcount(input logic [MAX_VEC_W-1:0] vec,
                                           input int unsigned width);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < MAX_VEC_W; i++) begin
      if (i < width) n = n + 32'(vec[i]);
    end
    return n;
  endfunction

  // Sum of the valid item_w-wide items packed in data, each zero-extended.
  function automatic logic [SUM_W-1:0] item_sum(input logic [MAX_VEC_W-1:0] data,
                                                input logic [MAX_VEC_W-1:0] vld,
                                                input int unsigned items,
                                                input int unsigned item_w);
    logic [SUM_W-1:0]     acc;
    logic [MAX_VEC_W-1:0] item;
    logic [MAX_VEC_W-1:0] item_mask;
    acc       = '0;
    item_mask = (MAX_VEC_W'(1) << item_w) - MAX_VEC_W'(1);
    for (int unsigned i = 0; i < MAX_VEC_W; i++) begin
      if (i < items && vld[i]) begin
        item = (data >> (i * item_w)) & item_mask;
        acc  = acc + SUM_W'(item);
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/frame_masker_credit_mask_gen.sv
// frame_masker_credit_mask_gen: combinational SOF release mask.
// A SOF in region r may pass when enabled and fewer than credit_i SOFs sit in
// the lower regions, so lower regions are served first.
// Ports:
//   sof_i    - SOF per region at the masker input
//   credit_i - registered credit count
//   en_i     - scheduler is RUNNING
//   mask_o   - 1 = SOF in region may pass
//   used_o   - number of released SOFs (popcount of mask_o)
module frame_masker_credit_mask_gen
  import frame_masker_credit_ctrl_pkg::*;
#(
  parameter int unsigned REGIONS   = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic [REGIONS-1:0]   sof_i,
  input  logic [CNT_WIDTH-1:0] credit_i,
  input  logic                 en_i,
  output logic [REGIONS-1:0]   mask_o,
  output logic [CNT_WIDTH-1:0] used_o
);

  // Prefix count of SOFs in lower regions compared against the credit.
  always_comb begin
    logic [CNT_WIDTH-1:0] seen;
    seen   = '0;
    mask_o = '0;
    for (int unsigned r = 0; r < REGIONS; r++) begin
      mask_o[r] = en_i && sof_i[r] && (seen < credit_i);
      seen      = seen + CNT_WIDTH'(sof_i[r]);
    end
  end

  assign used_o = CNT_WIDTH'(popcount(MAX_VEC_W'(mask_o), REGIONS));

endmodule

// File: rtl/frame_masker_credit_ctrl.sv
// frame_masker_credit_ctrl: credit-based release scheduler for the MFB frame
// masker. Credits granted over MVB accumulate in a register; the block drives a
// per-region SOF mask so only as many frames start as credits allow.
// Ports:
//   CLK, RESET              - clock, asynchronous active-high reset
//   CTRL_START / CTRL_STOP  - control pulses (STOP wins when both set)
//   CTRL_RUNNING            - scheduler is RUNNING
//   CREDIT_CNT              - current credit register
//   MVB_DATA/VLD/SRC_RDY    - credit items in; MVB_DST_RDY = room for a full word
//   MFB_SOF/SRC_RDY/DST_RDY - observed masker input SOFs and handshake
//   TX_MASK                 - 1 = SOF in region may pass
// Optional: define FRAME_MASKER_CREDIT_CTRL_STATS_EN to add STAT_CLR,
//   STAT_RELEASED and STAT_GRANTED (32-bit wrapping counters).
module frame_masker_credit_ctrl
  import frame_masker_credit_ctrl_pkg::*;
#(
  parameter int unsigned MFB_REGIONS    = 4,
  parameter int unsigned MVB_ITEMS      = 2,
  parameter int unsigned MVB_ITEM_WIDTH = 8,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic                                CTRL_START,
  input  logic                                CTRL_STOP,
  output logic                                CTRL_RUNNING,
  output logic [CNT_WIDTH-1:0]                CREDIT_CNT,
  input  logic [MVB_ITEMS*MVB_ITEM_WIDTH-1:0] MVB_DATA,
  input  logic [MVB_ITEMS-1:0]                MVB_VLD,
  input  logic                                MVB_SRC_RDY,
  output logic                                MVB_DST_RDY,
  input  logic [MFB_REGIONS-1:0]              MFB_SOF,
  input  logic                                MFB_SRC_RDY,
  input  logic                                MFB_DST_RDY,
  output logic [MFB_REGIONS-1:0]              TX_MASK
`ifdef FRAME_MASKER_CREDIT_CTRL_STATS_EN
  ,
  input  logic                                STAT_CLR,
  output logic [31:0]                         STAT_RELEASED,
  output logic [31:0]                         STAT_GRANTED
`endif
);

  // Largest credit value that can still absorb a full word of maximal items.
  localparam logic [CNT_WIDTH-1:0] RDY_LIMIT =
    {CNT_WIDTH{1'b1}} - CNT_WIDTH'(MVB_ITEMS) * CNT_WIDTH'({MVB_ITEM_WIDTH{1'b1}});

  ctrl_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0] credit_q, credit_d;
  logic [CNT_WIDTH-1:0] used_mask;
  logic [CNT_WIDTH-1:0] used;
  logic [CNT_WIDTH-1:0] grant_sum;
  logic [CNT_WIDTH-1:0] add;
  logic                 credit_room;

  frame_masker_credit_mask_gen #(
    .REGIONS   (MFB_REGIONS),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_mask_gen (
    .sof_i    (MFB_SOF),
    .credit_i (credit_q),
    .en_i     (state_q == RUNNING),
    .mask_o   (TX_MASK),
    .used_o   (used_mask)
  );

  // Room check uses only the register, so no MVB input reaches MVB_DST_RDY.
  assign credit_room = (credit_q <= RDY_LIMIT);
  assign MVB_DST_RDY = credit_room && !RESET;

  assign grant_sum = CNT_WIDTH'(item_sum(MAX_VEC_W'(MVB_DATA), MAX_VEC_W'(MVB_VLD),
                                         MVB_ITEMS, MVB_ITEM_WIDTH));

  // Control FSM next state; STOP has priority over START.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      STOPPED: if (CTRL_START && !CTRL_STOP) state_d = RUNNING;
      RUNNING: if (CTRL_STOP) state_d = STOPPED;
      default: state_d = STOPPED;
    endcase
  end

  // Credit update: used never exceeds credit_q, and room check prevents overflow.
  always_comb begin
    used     = (MFB_SRC_RDY && MFB_DST_RDY) ? used_mask : '0;
    add      = (MVB_SRC_RDY && credit_room) ? grant_sum : '0;
    credit_d = credit_q - used + add;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= STOPPED;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
    end
  end

  assign CTRL_RUNNING = (state_q == RUNNING);
  assign CREDIT_CNT   = credit_q;

`ifdef FRAME_MASKER_CREDIT_CTRL_STATS_EN
  logic [31:0] released_q, released_d;
  logic [31:0] granted_q, granted_d;

  // Clear has priority over accumulation; both counters wrap.
  always_comb begin
    released_d = released_q + 32'(used);
    granted_d  = granted_q + 32'(add);
    if (STAT_CLR) begin
      released_d = '0;
      granted_d  = '0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      released_q <= '0;
      granted_q  <= '0;
    end else begin
      released_q <= released_d;
      granted_q  <= granted_d;
    end
  end

  assign STAT_RELEASED = released_q;
  assign STAT_GRANTED  = granted_q;
`endif

endmodule

// File: tb/tb_frame_masker_credit_ctrl.sv
// tb_frame_masker_credit_ctrl: randomized and directed bench for the credit
// scheduler against a frame-level credit model (integer credit, greedy release).
module tb_frame_masker_credit_ctrl;

  localparam int unsigned REGIONS = 4;
  localparam int unsigned ITEMS   = 2;
  localparam int unsigned IW      = 8;
  localparam int unsigned CW      = 16;
  localparam int unsigned CREDIT_MAX = (1 << CW) - 1;
  localparam int unsigned ROOM_LIMIT = CREDIT_MAX - ITEMS * ((1 << IW) - 1);

  logic                  CLK = 1'b0;
  logic                  RESET;
  logic                  CTRL_START, CTRL_STOP, CTRL_RUNNING;
  logic [CW-1:0]         CREDIT_CNT;
  logic [ITEMS*IW-1:0]   MVB_DATA;
  logic [ITEMS-1:0]      MVB_VLD;
  logic                  MVB_SRC_RDY, MVB_DST_RDY;
  logic [REGIONS-1:0]    MFB_SOF;
  logic                  MFB_SRC_RDY, MFB_DST_RDY;
  logic [REGIONS-1:0]    TX_MASK;
`ifdef FRAME_MASKER_CREDIT_CTRL_STATS_EN
  logic                  STAT_CLR;
  logic [31:0]           STAT_RELEASED, STAT_GRANTED;
`endif

  frame_masker_credit_ctrl dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .CTRL_START   (CTRL_START),
    .CTRL_STOP    (CTRL_STOP),
    .CTRL_RUNNING (CTRL_RUNNING),
    .CREDIT_CNT   (CREDIT_CNT),
    .MVB_DATA     (MVB_DATA),
    .MVB_VLD      (MVB_VLD),
    .MVB_SRC_RDY  (MVB_SRC_RDY),
    .MVB_DST_RDY  (MVB_DST_RDY),
    .MFB_SOF      (MFB_SOF),
    .MFB_SRC_RDY  (MFB_SRC_RDY),
    .MFB_DST_RDY  (MFB_DST_RDY),
    .TX_MASK      (TX_MASK)
`ifdef FRAME_MASKER_CREDIT_CTRL_STATS_EN
    ,
    .STAT_CLR      (STAT_CLR),
    .STAT_RELEASED (STAT_RELEASED),
    .STAT_GRANTED  (STAT_GRANTED)
`endif
  );

  always #5 CLK = ~CLK;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state.
  int unsigned m_credit  = 0;
  bit          m_running = 1'b0;
  int unsigned m_released = 0;
  int unsigned m_granted  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credit   = 0;
    m_running  = 1'b0;
    m_released = 0;
    m_granted  = 0;
  endtask

  // One cycle: drive at negedge, compare against the model, advance the model.
  task automatic step(input logic [REGIONS-1:0] sof, input logic msrc, input logic mdst,
                      input logic [ITEMS*IW-1:0] data, input logic [ITEMS-1:0] vld,
                      input logic vsrc, input logic start, input logic stop,
                      input logic clr);
    logic [REGIONS-1:0] exp_mask;
    int unsigned        left, used, add;
    bit                 room;
    @(negedge CLK);
    MFB_SOF = sof; MFB_SRC_RDY = msrc; MFB_DST_RDY = mdst;
    MVB_DATA = data; MVB_VLD = vld; MVB_SRC_RDY = vsrc;
    CTRL_START = start; CTRL_STOP = stop;
`ifdef FRAME_MASKER_CREDIT_CTRL_STATS_EN
    STAT_CLR = clr;
`endif
    #1;
    // Greedy release: each SOF, lowest region first, spends one credit.
    exp_mask = '0;
    left     = m_credit;
    if (m_running) begin
      for (int r = 0; r < REGIONS; r++) begin
        if (sof[r] && left > 0) begin
          exp_mask[r] = 1'b1;
          left--;
        end
      end
    end
    room = (m_credit <= ROOM_LIMIT);
    check_eq("tx_mask", 32'(TX_MASK), 32'(exp_mask));
    check_eq("mvb_dst_rdy", 32'(MVB_DST_RDY), 32'(room));
    check_eq("credit_cnt", 32'(CREDIT_CNT), m_credit);
    check_eq("ctrl_running", 32'(CTRL_RUNNING), 32'(m_running));
`ifdef FRAME_MASKER_CREDIT_CTRL_STATS_EN
    check_eq("stat_released", STAT_RELEASED, m_released);
    check_eq("stat_granted", STAT_GRANTED, m_granted);
`endif
    used = (msrc && mdst) ? m_credit - left : 0;
    add  = 0;
    if (vsrc && room) begin
      for (int i = 0; i < ITEMS; i++)
        if (vld[i]) add += (data >> (i * IW)) % (1 << IW);
    end
    m_credit = m_credit - used + add;
    if (stop) m_running = 1'b0;
    else if (start) m_running = 1'b1;
    if (clr) begin
      m_released = 0;
      m_granted  = 0;
    end else begin
      m_released += used;
      m_granted  += add;
    end
  endtask

  task automatic idle();
    step('0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic grant(input int unsigned a, input int unsigned b, input logic [1:0] vld);
    step('0, 1'b0, 1'b0, {8'(b), 8'(a)}, vld, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    RESET = 1'b1;
    CTRL_START = 1'b0; CTRL_STOP = 1'b0;
    MVB_DATA = '0; MVB_VLD = '0; MVB_SRC_RDY = 1'b0;
    MFB_SOF = '0; MFB_SRC_RDY = 1'b0; MFB_DST_RDY = 1'b0;
`ifdef FRAME_MASKER_CREDIT_CTRL_STATS_EN
    STAT_CLR = 1'b0;
`endif
    #2;
    check_eq("rst_credit", 32'(CREDIT_CNT), 0);
    check_eq("rst_running", 32'(CTRL_RUNNING), 0);
    check_eq("rst_dst_rdy", 32'(MVB_DST_RDY), 0);
    check_eq("rst_mask", 32'(TX_MASK), 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    model_reset();

    // Grant 2+1 while stopped, then start and release three of four SOFs.
    grant(2, 1, 2'b11);
    step('0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("grant3_credit", 32'(CREDIT_CNT), 3);
    check_eq("grant3_mask_stopped", 32'(TX_MASK), 0);
    step(4'b1111, 1'b1, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("sof1111_mask", 32'(TX_MASK), 32'h7);
    idle();
    check_eq("drain_credit0", 32'(CREDIT_CNT), 0);

    // Masker stalls: mask shown but nothing consumed until DST_RDY.
    grant(2, 0, 2'b01);
    step(4'b1010, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("stall_mask", 32'(TX_MASK), 32'ha);
    step(4'b1010, 1'b1, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("stall_credit_kept", 32'(CREDIT_CNT), 2);
    idle();
    check_eq("stall_credit0", 32'(CREDIT_CNT), 0);

    // Same-cycle grant 5 and consume 2 from credit 2.
    grant(2, 0, 2'b01);
    step(4'b1111, 1'b1, 1'b1, {8'd0, 8'd5}, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("simul_mask_old", 32'(TX_MASK), 32'h3);
    idle();
    check_eq("simul_credit", 32'(CREDIT_CNT), 5);

    // START+STOP in RUNNING stops; credit retained, mask cleared.
    step(4'b1111, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("stop_mask0", 32'(TX_MASK), 0);
    check_eq("stop_credit", 32'(CREDIT_CNT), 5);
    // START+STOP while STOPPED stays STOPPED.
    step('0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();
    check_eq("both_stopped", 32'(CTRL_RUNNING), 0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      step(REGIONS'($urandom), 1'($urandom), 1'($urandom),
           {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))}, 2'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 31) == 0));
    end

    // Fill to the room limit while stopped; grants must stop being accepted.
    step('0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 135; n++) grant(255, 255, 2'b11);
    check_eq("full_dst_rdy", 32'(MVB_DST_RDY), 0);
    step('0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 80; n++)
      step(4'b1111, 1'b1, 1'b1, {8'd255, 8'd255}, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("full_no_wrap", 32'(CREDIT_CNT > CW'(60000)), 1);

    // Empty VLD word is accepted and adds nothing.
    step('0, 1'b0, 1'b0, {8'd9, 8'd9}, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid traffic with credit 7.
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    RESET = 1'b0;
    model_reset();
    grant(7, 0, 2'b01);
    step('0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(4'b0011, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("pre_rst_credit7", 32'(CREDIT_CNT), 7);
    #3;
    RESET = 1'b1;
    #1;
    check_eq("async_rst_credit", 32'(CREDIT_CNT), 0);
    check_eq("async_rst_mask", 32'(TX_MASK), 0);
    check_eq("async_rst_running", 32'(CTRL_RUNNING), 0);
    check_eq("async_rst_dst_rdy", 32'(MVB_DST_RDY), 0);
`ifdef FRAME_MASKER_CREDIT_CTRL_STATS_EN
    check_eq("async_rst_released", STAT_RELEASED, 0);
    check_eq("async_rst_granted", STAT_GRANTED, 0);
`endif
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
